// File: rtl/serializer.sv
// rtl/serializer.sv - SPI mode-0 return-path transmitter with a one-word buffer (optional header bit: SERIALIZER_VALID_HDR_EN)
module serializer #(
    parameter int DATAW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spi_clk,
    input  logic             cs_n,
    input  logic [DATAW-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             miso,
    output logic             tx_done
);

`ifdef SERIALIZER_VALID_HDR_EN
    localparam int FRAMEW = DATAW + 1;
`else
    localparam int FRAMEW = DATAW;
`endif
    localparam int              CNTW      = $clog2(FRAMEW + 1);
    localparam logic [CNTW-1:0] FRAME_CNT = CNTW'(FRAMEW);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic              sck_s1, sck_s2, sck_h;
    logic              cs_s1, cs_s2, cs_h;
    logic [1:0]        state;
    logic [DATAW-1:0]  hold_reg;
    logic              full;
    logic              loaded;
    logic [FRAMEW-1:0] shift_reg;
    logic [FRAMEW-1:0] frame_load;
    logic [CNTW-1:0]   bit_cnt;
    logic [CNTW-1:0]   cnt_inc;
    logic              sck_rise, sck_fall, cs_fall, cs_rise;

    assign sck_rise = sck_s2 & ~sck_h;
    assign sck_fall = ~sck_s2 & sck_h;
    assign cs_fall  = ~cs_s2 & cs_h;
    assign cs_rise  = cs_s2 & ~cs_h;
    assign cnt_inc  = bit_cnt + 1'b1;

    // An empty frame shifts zeros; with the header enabled the first bit flags a real word.
`ifdef SERIALIZER_VALID_HDR_EN
    assign frame_load = full ? {1'b1, hold_reg} : '0;
`else
    assign frame_load = full ? hold_reg : '0;
`endif

    assign ready_out = rst_n & ~full;
    assign miso      = (state == ST_SHIFT) ? shift_reg[FRAMEW-1] : 1'b0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sck_s1    <= 1'b0;
            sck_s2    <= 1'b0;
            sck_h     <= 1'b0;
            cs_s1     <= 1'b1;
            cs_s2     <= 1'b1;
            cs_h      <= 1'b1;
            state     <= ST_IDLE;
            hold_reg  <= '0;
            full      <= 1'b0;
            loaded    <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
            tx_done   <= 1'b0;
        end else begin
            sck_s1  <= spi_clk;
            sck_s2  <= sck_s1;
            sck_h   <= sck_s2;
            cs_s1   <= cs_n;
            cs_s2   <= cs_s1;
            cs_h    <= cs_s2;
            tx_done <= 1'b0;

            // Completion only clears full when it was set, so it never collides with an accept.
            if (valid_in && !full) begin
                hold_reg <= data_in;
                full     <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state     <= ST_SHIFT;
                        shift_reg <= frame_load;
                        bit_cnt   <= '0;
                        loaded    <= full;
                    end
                end
                ST_SHIFT: begin
                    if (cs_rise) begin
                        state <= ST_IDLE;
                    end else if (sck_rise) begin
                        if (bit_cnt != FRAME_CNT) begin
                            bit_cnt <= cnt_inc;
                        end
                        if (cnt_inc == FRAME_CNT) begin
                            state <= ST_DONE;
                            if (loaded) begin
                                tx_done <= 1'b1;
                                full    <= 1'b0;
                            end
                        end
                    end else if (sck_fall) begin
                        shift_reg <= {shift_reg[FRAMEW-2:0], 1'b0};
                    end
                end
                ST_DONE: begin
                    if (cs_rise) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serializer.sv
// tb/tb_serializer.sv - directed-vector bench for serializer
module tb_serializer;
    localparam int DW = 8;
`ifdef SERIALIZER_VALID_HDR_EN
    localparam int NB = DW + 1;
`else
    localparam int NB = DW;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          spi_clk = 1'b0;
    logic          cs_n = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          valid_in = 1'b0;
    logic          ready_out, miso, tx_done;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;

    serializer #(.DATAW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_clk  (spi_clk),
        .cs_n     (cs_n),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .miso     (miso),
        .tx_done  (tx_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_frame(input logic [DW-1:0] w, input bit ld);
        logic [31:0] r;
        r = 32'(w);
`ifdef SERIALIZER_VALID_HDR_EN
        r = r | (32'd1 << DW);
`endif
        return ld ? r : 32'd0;
    endfunction

    task automatic send_word(input logic [DW-1:0] w);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        data_in  = w;
        valid_in = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (ready_out) ok = 1'b1;
            @(negedge clk);
        end
        valid_in = 1'b0;
        check("accept", 32'(ok), 32'd1);
        check("ready_low_after_accept", 32'(ready_out), 32'd0);
    endtask

    task automatic spi_frame(input int npulses, output logic [31:0] got);
        got = '0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < npulses; i++) begin
            spi_clk = 1'b1;
            got = {got[30:0], miso};
            repeat (6) @(negedge clk);
            spi_clk = 1'b0;
            repeat (6) @(negedge clk);
        end
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    logic [31:0] bits;
    int d0;

    initial begin
        // reset
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready_out), 32'd0);
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(ready_out), 32'd1);
        repeat (4) @(negedge clk);

        // normal send
        send_word(8'hA5);
        d0 = done_cnt;
        spi_frame(NB, bits);
        check("a5_bits", bits, exp_frame(8'hA5, 1'b1));
        check("a5_done", 32'(done_cnt - d0), 32'd1);
        check("a5_ready", 32'(ready_out), 32'd1);

        // abort after 3 bits then retransmit
        send_word(8'h3C);
        d0 = done_cnt;
        spi_frame(3, bits);
        check("abort_bits", bits, exp_frame(8'h3C, 1'b1) >> (NB - 3));
        check("abort_done", 32'(done_cnt - d0), 32'd0);
        check("abort_ready", 32'(ready_out), 32'd0);
        spi_frame(NB, bits);
        check("retx_bits", bits, exp_frame(8'h3C, 1'b1));
        check("retx_done", 32'(done_cnt - d0), 32'd1);
        check("retx_ready", 32'(ready_out), 32'd1);

        // empty frame
        d0 = done_cnt;
        spi_frame(NB, bits);
        check("empty_bits", bits, 32'd0);
        check("empty_done", 32'(done_cnt - d0), 32'd0);
        check("empty_ready", 32'(ready_out), 32'd1);

        // accept mid-frame
        d0 = done_cnt;
        fork
            spi_frame(NB, bits);
            begin
                repeat (30) @(negedge clk);
                send_word(8'hFF);
            end
        join
        check("mid_bits", bits, 32'd0);
        check("mid_done", 32'(done_cnt - d0), 32'd0);
        check("mid_ready", 32'(ready_out), 32'd0);
        spi_frame(NB, bits);
        check("ff_bits", bits, exp_frame(8'hFF, 1'b1));
        check("ff_done", 32'(done_cnt - d0), 32'd1);

        // extra clocks
        send_word(8'h81);
        d0 = done_cnt;
        spi_frame(NB + 4, bits);
        check("extra_bits", bits, exp_frame(8'h81, 1'b1) << 4);
        check("extra_done", 32'(done_cnt - d0), 32'd1);
        check("extra_ready", 32'(ready_out), 32'd1);

        // reset mid-frame
        send_word(8'h5A);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        bits = '0;
        for (int i = 0; i < 4; i++) begin
            spi_clk = 1'b1;
            bits = {bits[30:0], miso};
            repeat (6) @(negedge clk);
            spi_clk = 1'b0;
            repeat (6) @(negedge clk);
        end
        check("pre_rst_bits", bits, exp_frame(8'h5A, 1'b1) >> (NB - 4));
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_miso", 32'(miso), 32'd0);
        check("midrst_ready", 32'(ready_out), 32'd0);
        cs_n = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_ready", 32'(ready_out), 32'd1);
        repeat (6) @(negedge clk);
        d0 = done_cnt;
        spi_frame(NB, bits);
        check("after_rst_bits", bits, 32'd0);
        check("after_rst_done", 32'(done_cnt - d0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/serializer.md
# serializer

Return-path SPI transmitter for the control group. It accepts one response word from the core over a valid/ready handshake and holds it in a single-entry buffer. It then shifts the word out MSB-first on `miso` during the next SPI frame driven by the external CPU. Everything runs on the fast chip clock `clk`; `spi_clk` and `cs_n` are synchronized into `clk` and edge-detected, never used as clocks.

## Interface
- `DATAW`, default 8: response word width, in bits; minimum 2.
- `clk`  input  1: chip clock; all state updates on its rising edge.
- `rst_n`  input  1: reset, synchronous and active-low.
- `spi_clk`  input  1: SPI serial clock from the CPU, asynchronous to `clk`.
- `cs_n`  input  1: SPI chip select, active-low, asynchronous.
- `data_in`  input  DATAW: response word.
- `valid_in`  input  1: `data_in` valid.
- `ready_out`  output  1: buffer empty; the word is accepted when `valid_in && ready_out`.
- `miso`  output  1: serial data to the CPU.
- `tx_done`  output  1: one-cycle pulse when a loaded word has been fully transmitted.

## Operation
- **Synchronizers.** `spi_clk` and `cs_n` each pass through 2 flops plus a history flop. Edge detects compare the sync output with the history flop.
- **SPI format.** SPI mode 0. The CPU samples on `spi_clk` rising edges. The block changes `miso` only after a detected `spi_clk` falling edge or at frame start.
- **Buffer.**
  - One `DATAW` holding register plus a `full` flag; `ready_out = !full`.
  - On accept, capture `data_in` and set `full`.
  - `full` clears only on frame completion (with `tx_done`).
- **States.**
  - IDLE: sync `cs_n` high; `miso` = 0.
  - SHIFT: sync `cs_n` low and bit counter < DATAW.
  - DONE: frame complete but `cs_n` still low; `miso` = 0; further `spi_clk` edges are ignored.
- **Transitions.**
  - IDLE→SHIFT on a sync `cs_n` falling edge. The shift register loads the holding register if `full`, else all zeros (empty frame). The counter clears and `miso` drives the shift MSB in that same cycle.
  - In SHIFT, each sync `spi_clk` rising edge increments the counter. Each falling edge shifts left and drives the next bit.
  - SHIFT→DONE when the counter reaches DATAW. If the frame carried a loaded word: pulse `tx_done` and clear `full`.
  - Any state→IDLE on a sync `cs_n` rising edge.
- **Abort.** `cs_n` rising in SHIFT before DATAW rising edges aborts the frame. `full` and the holding register are unchanged; the next frame retransmits the same word from the MSB. No `tx_done`.
- **Accept during frame.** A word accepted mid-frame (empty frame in flight) is not inserted into the current frame; it goes out in the next frame.
- **Simultaneous events.** Frame completion and `valid_in` in the same cycle: `ready_out` is still 0 that cycle. The new word is accepted no earlier than the following cycle.
- **Widths.** Bit counter is `$clog2(DATAW+1)` bits and saturates at DATAW.

## Timing
- **Reset** (`rst_n` low at a `clk` edge):
  - state IDLE; `full` = 0; synchronizer and history flops = 1 for `cs_n`, 0 for `spi_clk`.
  - outputs: `miso` = 0, `tx_done` = 0, `ready_out` = 0 during reset, 1 from the first cycle after.
  - A frame in progress is dropped and the buffered word is lost.
- **Input-to-action latency:** 3 `clk` cycles from an `spi_clk`/`cs_n` pin edge to the resulting state change.
- **Clock ratio:** `spi_clk` high and low phases are each ≥ 4 `clk` periods. The `cs_n` fall to first `spi_clk` rise is ≥ 4 `clk` periods.
- **`tx_done`:** asserted the cycle after the DATAW-th sync rising edge is detected; `ready_out` rises in the same cycle.
- **`miso` change:** 1 cycle after the sync falling edge is detected.

## Configuration
- `SERIALIZER_VALID_HDR_EN` defined:
  - Each frame is DATAW+1 bits. The first bit is a header: 1 if the frame carries a buffered word, 0 for an empty frame.
  - Completion requires DATAW+1 rising edges; the counter widens to `$clog2(DATAW+2)`.
- Undefined: frames are DATAW bits with no header. An empty frame shifts all zeros and is indistinguishable from a word of 0.

## Test plan
- **Normal send.** DATAW=8; accept 0xA5, then 8-clock frame → CPU samples 1,0,1,0,0,1,0,1. Single `tx_done` pulse; `ready_out` returns to 1.
- **Abort and retransmit.** Accept 0x3C; raise `cs_n` after 3 rising edges → no `tx_done`, `ready_out` stays 0. Next full frame → 0,0,1,1,1,1,0,0 plus `tx_done`.
- **Empty frame.** Frame with no word buffered → 8 zeros (`SERIALIZER_VALID_HDR_EN`: 9 zeros), no `tx_done`, `full` unaffected.
- **Accept mid-frame.** Offer 0xFF during an empty frame → accepted (`ready_out` falls), current frame still all zeros. Next frame sends 0xFF.
- **Extra clocks.** 12 `spi_clk` pulses after 0x81 → bits 1,0,0,0,0,0,0,1, then `miso` = 0 for the 4 extra pulses. Exactly one `tx_done`.
- **Reset mid-frame.** `rst_n` low after 4 bits of 0x5A → `miso` = 0, `ready_out` = 0 during reset, 1 after. Next frame is empty (all zeros).
